// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: requester side of a combinational instruction memory.
// Holds the byte PC, presents the word index, and captures the returned
// instruction into the IF/ID register. Handles stall, branch redirect, halt
// detection and fetch/bubble performance counters.
//
// Ports:
//   clk, reset         - clock; asynchronous active-high reset
//   imem_addr          - word index {2'b00, pc[63:2]} (combinational)
//   imem_instruction   - instruction for imem_addr, same cycle
//   stall              - hold IF and IF/ID
//   branch_taken/_target - redirect request from EX
//   pc                 - current fetch byte address
//   if_id_pc/_instr/_valid - IF/ID pipeline register
//   halted             - high while in HALT
//   misaligned         - sticky, set on a redirect target with [1:0] != 0
//   fetch_count        - saturating count of instructions issued into IF/ID
//   bubble_count       - saturating count of RUN/HALT cycles with no issue
module if_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          MEM_DEPTH = 64,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instruction,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] pc,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        halted,
  output logic        misaligned,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state, state_n;
  logic [63:0] pc_n, if_id_pc_n;
  logic [31:0] if_id_instr_n;
  logic        if_id_valid_n, misaligned_n;
  logic        fetch_inc, bubble_inc, bubble_ld;
  logic        out_of_range, tgt_mis;

  assign imem_addr    = {2'b00, pc[63:2]};
  assign out_of_range = imem_addr >= 64'(MEM_DEPTH);
  assign tgt_mis      = branch_target[1:0] != 2'b00;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_n;
  end

  // Next-state and datapath decisions
  always_comb begin
    state_n       = state;
    pc_n          = pc;
    if_id_pc_n    = if_id_pc;
    if_id_instr_n = if_id_instr;
    if_id_valid_n = if_id_valid;
    misaligned_n  = misaligned;
    fetch_inc     = 1'b0;
    bubble_inc    = 1'b0;
    bubble_ld     = 1'b0;
    unique case (state)
      BOOT: state_n = RUN;
      RUN: begin
        if (branch_taken) begin
          // redirect beats stall; a bad target parks the fetcher in HALT
          bubble_ld  = 1'b1;
          bubble_inc = 1'b1;
          if (tgt_mis) begin
            misaligned_n = 1'b1;
            state_n      = HALT;
          end else begin
            pc_n = branch_target;
          end
        end else if (stall) begin
          bubble_inc = 1'b1;
        end else if (out_of_range || imem_instruction == 32'h0) begin
          bubble_ld  = 1'b1;
          bubble_inc = 1'b1;
          state_n    = HALT;
        end else begin
          if_id_pc_n    = pc;
          if_id_instr_n = imem_instruction;
          if_id_valid_n = 1'b1;
          pc_n          = pc + 64'd4;
          fetch_inc     = 1'b1;
        end
      end
      HALT: begin
        // halt may come from fetching past an unresolved branch, so an
        // aligned redirect resumes fetching
        bubble_ld  = 1'b1;
        bubble_inc = 1'b1;
        if (branch_taken) begin
          if (tgt_mis) begin
            misaligned_n = 1'b1;
          end else begin
            pc_n    = branch_target;
            state_n = RUN;
          end
        end
      end
      default: state_n = BOOT;
    endcase
    if (bubble_ld) begin
      if_id_pc_n    = 64'h0;
      if_id_instr_n = NOP_INSTR;
      if_id_valid_n = 1'b0;
    end
  end

  // Datapath registers and saturating counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc           <= RESET_PC;
      if_id_pc     <= 64'h0;
      if_id_instr  <= NOP_INSTR;
      if_id_valid  <= 1'b0;
      halted       <= 1'b0;
      misaligned   <= 1'b0;
      fetch_count  <= 32'h0;
      bubble_count <= 32'h0;
    end else begin
      pc          <= pc_n;
      if_id_pc    <= if_id_pc_n;
      if_id_instr <= if_id_instr_n;
      if_id_valid <= if_id_valid_n;
      halted      <= (state_n == HALT);
      misaligned  <= misaligned_n;
      if (fetch_inc && fetch_count != 32'hFFFF_FFFF)
        fetch_count <= fetch_count + 32'd1;
      if (bubble_inc && bubble_count != 32'hFFFF_FFFF)
        bubble_count <= bubble_count + 32'd1;
    end
  end

endmodule
